r3_sdf_ctrl: RTL and testbench
==============================

Name: r3_sdf_ctrl

Overview:
Sequencing controller for one radix-3 single-delay-feedback (SDF) FFT stage. The stage's datapath is two DLY-deep complex delay lines, a radix-3 butterfly and a twiddle multiplier. This block counts accepted samples into phase/index and drives the delay-line shift enable, the feedback mux select and the butterfly enable. It also generates the twiddle exponent, the output valid/start-of-frame strobes and an end-of-stream flush.

Parameters:
DLY, 9, delay-line depth; frame length is 3*DLY samples
IW, clog2(DLY), width of idx
TW_W, clog2(3*DLY), width of tw_exp

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample present this cycle
in_sof  in  1  qualifies the in_valid sample as the first sample of a frame
in_ready  out  1  controller accepts input; 0 only in FLUSH
flush  in  1  single-cycle request to drain the last frame
shift_en  out  1  advance both delay lines
fb_sel  out  1  0 = input feeds delay lines and delay output goes to stage output; 1 = butterfly results feed delay lines
bf_en  out  1  butterfly result is valid
phase  out  2  input phase p of the current strobe (0..2)
idx  out  IW  index n within the phase (0..DLY-1)
out_phase  out  2  which output is emitted: 0 = X0, 1 = X1, 2 = X2
tw_exp  out  TW_W  twiddle exponent
out_valid  out  1  stage output is valid
out_sof  out  1  first valid output of a frame
busy  out  1  state is not IDLE

Behaviour:
- Accept = in_valid & in_ready. A sample accepted at cycle t produces its control outputs, registered, at t+1. A strobe is either an accept or an internal FLUSH step.
- Reset (async, rst_n=0): state IDLE, p=0, n=0, fill=1. All outputs 0 except in_ready, which is 1.
- States:
  - IDLE: accepts with in_sof=0 are discarded and produce no strobe. An accept with in_sof=1 goes to RUN and is strobed as (0,0).
  - RUN: each strobe advances n. When n reaches DLY-1, n wraps to 0 and p advances; p wraps 2->0.
  - FLUSH: in_ready=0. Generates one internal strobe per cycle for (p,n) = (0,0)..(1,DLY-1), 2*DLY strobes in total, then goes to IDLE.
- Per-strobe outputs:
  - shift_en=1.
  - bf_en and fb_sel = (p==2).
  - out_phase: 0 if p==2, 1 if p==0, 2 if p==1.
  - tw_exp = (out_phase*n) mod 3*DLY.
  - out_valid = !(fill & p!=2).
  - out_sof = (p==2 & n==0).
  - On non-strobe cycles all of these are 0 (phase/idx hold their values).
- fill is set on every in_sof and cleared at the p2->p0 wrap. This suppresses the drain outputs of the first frame.
- in_sof in RUN:
  - At (p,n)=(0,0) expected position: no effect.
  - Elsewhere: resync. The counter forces (0,0) for that sample and fill=1; the partial frame is discarded.
- flush:
  - In IDLE: ignored.
  - In RUN: latched pending. It takes effect at the next frame boundary, i.e. the first cycle after the strobe (2,DLY-1) is issued; FLUSH is entered then.
  - flush and in_sof in the same cycle: in_sof is processed first and the pending flush is cleared.
- rst_n asserted mid-frame or mid-flush: immediate return to reset values; no drain.

Optional Feature:
R3_CTRL_ERR_EN
- Defined:
  - Adds output sof_err (1 bit): single-cycle pulse, registered, on every resync.
  - Adds output frame_cnt (16 bit): increments on each p2->p0 wrap, wraps at 0xFFFF->0, reset to 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package r3_pkg:
  - clog2 function.
  - State encodings IDLE=0, RUN=1, FLUSH=2.
  - Phase and out_phase encodings.
  - DLY default constant.
- Sub-module r3_mod_cnt: index/phase counter with enable, synchronous load-to-zero and wrap flag, parameterised by modulus. Instantiated twice: modulus DLY for n, modulus 3 for p.

Test Plan:
1. DLY=9: reset, then 27 continuous valids with in_sof on the first. The first 18 strobes have out_valid=0. Strobes 19..27 have out_valid=1, bf_en=1, out_sof on strobe 19, tw_exp=0.
2. Second 27-sample frame with no in_sof. At p=0, n=4: out_phase=1, tw_exp=4. At p=1, n=5: out_phase=2, tw_exp=10. All 27 strobes have out_valid=1.
3. Random in_valid gaps (50% density). Strobe count equals accept count. phase/idx hold across gaps. No shift_en is asserted without an accept.
4. in_sof at (1,3): the next strobe is (0,0). sof_err pulses (if R3_CTRL_ERR_EN). The following 18 strobes have out_valid=0.
5. flush pulse at (2,2): FLUSH starts after (2,8). in_ready=0 for 18 cycles, producing 18 strobes with out_valid=1. Then IDLE with busy=0, in_ready=1.
6. rst_n low mid-FLUSH: all outputs drop to 0 asynchronously. After release, in_ready=1 and inputs without in_sof are ignored.

Source files
------------

// File: rtl/r3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | r3_pkg                                                                     |
// | Shared encodings and helpers for the radix-3 SDF stage controller.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package r3_pkg;

    localparam int c_dly_default = 9;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;

    localparam logic [1:0] c_ph_0 = 2'd0;
    localparam logic [1:0] c_ph_1 = 2'd1;
    localparam logic [1:0] c_ph_2 = 2'd2;

    localparam logic [1:0] c_op_x0 = 2'd0;
    localparam logic [1:0] c_op_x1 = 2'd1;
    localparam logic [1:0] c_op_x2 = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Input phase p selects which butterfly output leaves the stage.
    function automatic logic [1:0] out_phase_of(input logic [1:0] p);
        case (p)
            c_ph_0:  return c_op_x1;
            c_ph_1:  return c_op_x2;
            default: return c_op_x0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/r3_mod_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | r3_mod_cnt                                                                 |
// | Modulo-MOD counter with enable, synchronous clear and wrap flag.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module r3_mod_cnt #(
    parameter int MOD = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic [W-1:0] q_nxt,
    output logic         wrap
);

    localparam logic [W-1:0] c_last = W'(MOD - 1);

    logic [W-1:0] r_q;

    always_comb begin
        q_nxt = r_q;
        wrap  = 1'b0;
        if (clr) begin
            q_nxt = '0;
        end else if (en) begin
            if (r_q == c_last) begin
                q_nxt = '0;
                wrap  = 1'b1;
            end else begin
                q_nxt = r_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= q_nxt;
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/r3_sdf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | r3_sdf_ctrl                                                                |
// | Sequencer for one radix-3 SDF FFT stage. Optional R3_CTRL_ERR_EN adds      |
// | sof_err / frame_cnt status outputs.                                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module r3_sdf_ctrl
    import r3_pkg::*;
#(
    parameter int DLY  = c_dly_default,
    parameter int IW   = clog2(DLY),
    parameter int TW_W = clog2(3 * DLY)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    input  logic            flush,
    output logic            shift_en,
    output logic            fb_sel,
    output logic            bf_en,
    output logic [1:0]      phase,
    output logic [IW-1:0]   idx,
    output logic [1:0]      out_phase,
    output logic [TW_W-1:0] tw_exp,
    output logic            out_valid,
    output logic            out_sof,
`ifdef R3_CTRL_ERR_EN
    output logic            sof_err,
    output logic [15:0]     frame_cnt,
`endif
    output logic            busy
);

    localparam logic [IW-1:0] c_n_last = IW'(DLY - 1);
    localparam int            c_frame  = 3 * DLY;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_fill;
    logic            r_pend;
    logic            w_accept;
    logic            w_sof_acc;
    logic            w_at_start;
    logic            w_start;
    logic            w_resync;
    logic            w_load;
    logic            w_strobe;
    logic            w_n_wrap;
    logic            w_p_wrap;
    logic            w_frame_end;
    logic            w_flush_last;
    logic            w_fill_eff;
    logic [IW-1:0]   w_n_nxt;
    logic [1:0]      w_p_nxt;
    logic [1:0]      w_op;
    logic [TW_W-1:0] w_tw;

    assign w_accept   = in_valid & in_ready;
    assign w_sof_acc  = w_accept & in_sof;
    // phase/idx hold the last strobed position, so (2,DLY-1) means a new frame is due.
    assign w_at_start = (phase == c_ph_2) && (idx == c_n_last);
    assign w_start    = (r_state == c_st_idle) & w_sof_acc;
    assign w_resync   = (r_state == c_st_run) & w_sof_acc & ~w_at_start;
    assign w_load     = w_start | w_resync;
    assign w_strobe   = w_start | ((r_state == c_st_run) & w_accept) | (r_state == c_st_flush);

    r3_mod_cnt #(.MOD(DLY), .W(IW)) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_strobe),
        .clr   (w_load),
        .q     (idx),
        .q_nxt (w_n_nxt),
        .wrap  (w_n_wrap)
    );

    r3_mod_cnt #(.MOD(3), .W(2)) u_phase_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_n_wrap),
        .clr   (w_load),
        .q     (phase),
        .q_nxt (w_p_nxt),
        .wrap  (w_p_wrap)
    );

    assign w_frame_end  = w_strobe & (w_p_nxt == c_ph_2) & (w_n_nxt == c_n_last);
    assign w_flush_last = (r_state == c_st_flush) & (w_p_nxt == c_ph_1) & (w_n_nxt == c_n_last);
    // The strobe that performs the p2->p0 wrap already belongs to a filled frame.
    assign w_fill_eff   = w_load | (r_fill & ~w_p_wrap);
    assign w_op         = out_phase_of(w_p_nxt);
    assign w_tw         = TW_W'((int'(w_op) * int'(w_n_nxt)) % c_frame);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_start) w_state_nxt = c_st_run;
            c_st_run:   if (w_frame_end && (r_pend || flush) && !w_sof_acc) w_state_nxt = c_st_flush;
            c_st_flush: if (w_flush_last) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready = (r_state != c_st_flush);
        busy     = (r_state != c_st_idle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill    <= 1'b1;
            r_pend    <= 1'b0;
            shift_en  <= 1'b0;
            fb_sel    <= 1'b0;
            bf_en     <= 1'b0;
            out_phase <= c_op_x0;
            tw_exp    <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            if (w_load)        r_fill <= 1'b1;
            else if (w_p_wrap) r_fill <= 1'b0;

            // A frame start always wins over an outstanding flush request.
            if (r_state != c_st_run || w_sof_acc || w_state_nxt == c_st_flush) r_pend <= 1'b0;
            else if (flush)                                                      r_pend <= 1'b1;

            shift_en  <= w_strobe;
            fb_sel    <= w_strobe & (w_p_nxt == c_ph_2);
            bf_en     <= w_strobe & (w_p_nxt == c_ph_2);
            out_phase <= w_strobe ? w_op : c_op_x0;
            tw_exp    <= w_strobe ? w_tw : '0;
            out_valid <= w_strobe & ~(w_fill_eff & (w_p_nxt != c_ph_2));
            out_sof   <= w_strobe & (w_p_nxt == c_ph_2) & (w_n_nxt == '0);
        end
    end

`ifdef R3_CTRL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_err   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            sof_err <= w_resync;
            if (w_p_wrap) frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_r3_sdf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_r3_sdf_ctrl                                                             |
// | Scoreboard bench for r3_sdf_ctrl against a frame-position reference model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_r3_sdf_ctrl;

    localparam int DLY   = 9;
    localparam int IW    = 4;
    localparam int TW_W  = 5;
    localparam int FRAME = 3 * DLY;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_sof = 1'b0;
    logic            flush = 1'b0;
    logic            in_ready;
    logic            shift_en;
    logic            fb_sel;
    logic            bf_en;
    logic [1:0]      phase;
    logic [IW-1:0]   idx;
    logic [1:0]      out_phase;
    logic [TW_W-1:0] tw_exp;
    logic            out_valid;
    logic            out_sof;
    logic            busy;
`ifdef R3_CTRL_ERR_EN
    logic            sof_err;
    logic [15:0]     frame_cnt;
`endif

    r3_sdf_ctrl #(.DLY(DLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .flush     (flush),
        .shift_en  (shift_en),
        .fb_sel    (fb_sel),
        .bf_en     (bf_en),
        .phase     (phase),
        .idx       (idx),
        .out_phase (out_phase),
        .tw_exp    (tw_exp),
        .out_valid (out_valid),
        .out_sof   (out_sof),
`ifdef R3_CTRL_ERR_EN
        .sof_err   (sof_err),
        .frame_cnt (frame_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int strobe;
        int p;
        int n;
        int op;
        int tw;
        int vld;
        int sof;
        int err;
        int frames;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Reference model: position within the 3*DLY frame of the last strobe.
    int m_mode, m_pos, m_fill, m_pend, m_left, m_frames;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc_cnt);
    endtask

    task automatic model_step(input bit v, input bit s, input bit f, output exp_t e);
        bit acc;
        int prev;
        bit loaded;
        e.due = 0; e.strobe = 0; e.p = 0; e.n = 0; e.op = 0; e.tw = 0;
        e.vld = 0; e.sof = 0; e.err = 0; e.frames = 0;
        acc    = v && (m_mode != M_FLUSH);
        prev   = m_pos;
        loaded = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (acc && s) begin
                    e.strobe = 1; m_pos = 0; m_fill = 1; loaded = 1'b1; m_mode = M_RUN;
                end
            end
            M_RUN: begin
                if (acc && s) m_pend = 0;
                else if (f)   m_pend = 1;
                if (acc) begin
                    e.strobe = 1;
                    if (s && m_pos != FRAME - 1) begin
                        m_pos = 0; m_fill = 1; loaded = 1'b1; e.err = 1;
                    end else begin
                        m_pos = (m_pos + 1) % FRAME;
                    end
                end
            end
            default: begin
                e.strobe = 1;
                m_pos = (m_pos + 1) % FRAME;
                m_left--;
            end
        endcase
        if (e.strobe && !loaded && prev == FRAME - 1) begin
            m_fill = 0;
            m_frames = (m_frames + 1) % 65536;
        end
        e.p = m_pos / DLY;
        e.n = m_pos % DLY;
        if (e.strobe) begin
            e.op  = (e.p + 1) % 3;
            e.tw  = (e.op * e.n) % FRAME;
            e.vld = (m_fill != 0 && e.p != 2) ? 0 : 1;
            e.sof = (m_pos == 2 * DLY) ? 1 : 0;
        end
        if (m_mode == M_RUN && e.strobe && m_pos == FRAME - 1 && m_pend != 0) begin
            m_mode = M_FLUSH; m_pend = 0; m_left = 2 * DLY;
        end else if (m_mode == M_FLUSH && m_left == 0) begin
            m_mode = M_IDLE;
        end
        e.frames = m_frames;
    endtask

    task automatic drive(input bit v, input bit s, input bit f);
        exp_t e;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), (m_mode != M_FLUSH) ? 1 : 0);
        chk("busy", 32'(busy), (m_mode != M_IDLE) ? 1 : 0);
        in_valid = v;
        in_sof   = s;
        flush    = f;
        model_step(v, s, f, e);
        e.due = cyc_cnt + 1;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        flush    = 1'b0;
        #1;
        sb.delete();
        chk("rst_outs", 32'({shift_en, fb_sel, bf_en, phase, idx, out_phase, tw_exp,
                             out_valid, out_sof, busy}), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
`ifdef R3_CTRL_ERR_EN
        chk("rst_err_outs", 32'({sof_err, frame_cnt}), 0);
`endif
        m_mode = M_IDLE; m_pos = 0; m_fill = 1; m_pend = 0; m_left = 0; m_frames = 0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (!(m_mode == M_RUN && m_pos == target) && guard < 100) begin
            drive(1'b1, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 100) bound_fail("run_to");
    endtask

    task automatic run_until_mode(input int mode, input bit v);
        int guard;
        guard = 0;
        while (m_mode != mode && guard < 100) begin
            drive(v, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 100) bound_fail("wait_mode");
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (mon_en && sb.size() > 0 && sb[0].due <= cyc_cnt) begin
                e = sb.pop_front();
                chk("shift_en", 32'(shift_en), e.strobe);
                chk("phase", 32'(phase), e.p);
                chk("idx", 32'(idx), e.n);
                if (e.strobe != 0) begin
                    chk("fb_sel", 32'(fb_sel), (e.p == 2) ? 1 : 0);
                    chk("bf_en", 32'(bf_en), (e.p == 2) ? 1 : 0);
                    chk("out_phase", 32'(out_phase), e.op);
                    chk("tw_exp", 32'(tw_exp), e.tw);
                    chk("out_valid", 32'(out_valid), e.vld);
                    chk("out_sof", 32'(out_sof), e.sof);
                end else begin
                    chk("idle_outs", 32'({fb_sel, bf_en, out_valid, out_sof, out_phase, tw_exp}), 0);
                end
`ifdef R3_CTRL_ERR_EN
                chk("sof_err", 32'(sof_err), e.err);
                chk("frame_cnt", 32'(frame_cnt), e.frames);
`endif
            end
        end
    end

    initial begin
        do_reset();

        // First frame: drain outputs suppressed until p=2.
        drive(1'b1, 1'b1, 1'b0);
        repeat (FRAME - 1) drive(1'b1, 1'b0, 1'b0);
        // Second frame, no in_sof: everything valid.
        repeat (FRAME) drive(1'b1, 1'b0, 1'b0);

        // Gapped input.
        repeat (150) drive(1'($urandom % 2), 1'b0, 1'b0);

        // Resync at (1,3).
        run_to(DLY + 2);
        drive(1'b1, 1'b1, 1'b0);
        repeat (30) drive(1'b1, 1'b0, 1'b0);

        // Flush request at (2,2), drain to IDLE.
        run_to(2 * DLY + 1);
        drive(1'b1, 1'b0, 1'b1);
        run_until_mode(M_FLUSH, 1'b1);
        run_until_mode(M_IDLE, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 1'b0);

        // Reset in the middle of a flush.
        drive(1'b1, 1'b1, 1'b0);
        repeat (FRAME) drive(1'b1, 1'b0, 1'b0);
        run_to(2 * DLY + 3);
        drive(1'b1, 1'b0, 1'b1);
        run_until_mode(M_FLUSH, 1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        do_reset();
        repeat (10) drive(1'b1, 1'b0, 1'b0);

        // Mixed random traffic with restarts, resyncs and flushes.
        repeat (400) begin
            bit v, s, f;
            v = ($urandom % 10) < 7;
            s = ($urandom % 40) == 0;
            f = ($urandom % 50) == 0;
            if (m_mode == M_IDLE && ($urandom % 4) == 0) s = 1'b1;
            if (s && m_mode == M_RUN && m_pos == FRAME - 1) s = 1'b0;
            if (s) f = 1'b0;
            drive(v, s, f);
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
